// File: rtl/ddr3_ui_pkg.sv
// ddr3_ui_pkg: shared widths, command encodings and write-beat layout for the DDR3 UI responder
package ddr3_ui_pkg;
    localparam int DATA_W = 288;
    localparam int MASK_W = 36;
    localparam int ADDR_W = 32;
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;
    typedef struct packed {
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
    } wdf_beat_t;
endpackage

// File: rtl/ddr3_ui_wdf_fifo.sv
// ddr3_ui_wdf_fifo: 4-entry synchronous FIFO holding write data beats with their byte masks
module ddr3_ui_wdf_fifo
    import ddr3_ui_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  wdf_beat_t i_data,
    input  logic      i_pop,
    output wdf_beat_t o_data,
    output logic      o_full,
    output logic      o_empty
);
    logic [2:0] r_wp;
    logic [2:0] r_rp;
    wdf_beat_t  r_buf [4];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 3'd1;
            if (i_pop) r_rp <= r_rp + 3'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_buf[r_wp[1:0]] <= i_data;
    end
    assign o_data  = r_buf[r_rp[1:0]];
    assign o_full  = (r_wp[1:0] == r_rp[1:0]) && (r_wp[2] != r_rp[2]);
    assign o_empty = r_wp == r_rp;
endmodule

// File: rtl/ddr3_ui_responder.sv
// ddr3_ui_responder: DDR3 UI-side memory model with init delay, write-data FIFO and pipelined reads
module ddr3_ui_responder
    import ddr3_ui_pkg::*;
#(
    parameter int ADDR_LSB     = 3,
    parameter int DEPTH_LOG2   = 8,
    parameter int RD_LATENCY   = 4,
    parameter int INIT_CYCLES  = 64,
    parameter int STALL_PERIOD = 0
)(
    input  logic              ddr3_app_clk,
    input  logic              ddr3_rst_n,
    input  logic [ADDR_W-1:0] app_addr,
    input  logic [2:0]        app_cmd,
    input  logic              app_en,
    input  logic [DATA_W-1:0] app_wdf_data,
    input  logic [MASK_W-1:0] app_wdf_mask,
    input  logic              app_wdf_wren,
    input  logic              app_wdf_end,
    output logic              app_rdy,
    output logic              app_wdf_rdy,
    output logic [DATA_W-1:0] app_rd_data,
    output logic              app_rd_data_valid,
    output logic              app_rd_data_end,
    output logic              phy_rdy,
    output logic              err_wdf_end,
    output logic              err_cmd
);
    logic [15:0]                            r_init_cnt;
    logic [15:0]                            r_stall_cnt;
    logic                                   r_phy_rdy;
    logic                                   r_wr_pending;
    logic [DEPTH_LOG2-1:0]                  r_wr_idx;
    logic                                   r_err_wdf_end;
    logic                                   r_err_cmd;
    logic [RD_LATENCY-1:0]                  r_vld;
    logic [RD_LATENCY-2:0][DATA_W-1:0]      r_dq;
    logic [DATA_W-1:0]                      r_rd_data;
    logic [DATA_W-1:0]                      r_mem [2**DEPTH_LOG2];
    logic                                   w_stall;
    logic                                   w_cmd_acc;
    logic                                   w_is_wr;
    logic                                   w_is_rd;
    logic                                   w_push;
    logic                                   w_commit;
    logic                                   w_full;
    logic                                   w_empty;
    logic [DEPTH_LOG2-1:0]                  w_idx;
    logic [DATA_W-1:0]                      w_keep;
    wdf_beat_t                              w_head;
    logic                                   w_unused;
    assign w_idx       = app_addr[ADDR_LSB+DEPTH_LOG2-1:ADDR_LSB];
    assign w_unused    = ^{app_addr[ADDR_W-1:ADDR_LSB+DEPTH_LOG2], app_addr[ADDR_LSB-1:0]};
    assign w_stall     = (STALL_PERIOD != 0) && (r_stall_cnt == 16'(STALL_PERIOD - 1));
    assign app_rdy     = r_phy_rdy & ~r_wr_pending & ~w_stall;
    assign app_wdf_rdy = r_phy_rdy & ~w_full;
    assign w_cmd_acc   = app_en & app_rdy;
    assign w_is_wr     = app_cmd == CMD_WRITE;
    assign w_is_rd     = app_cmd == CMD_READ;
    assign w_push      = app_wdf_wren & app_wdf_rdy;
    assign w_commit    = r_wr_pending & ~w_empty;
    assign phy_rdy           = r_phy_rdy;
    assign err_wdf_end       = r_err_wdf_end;
    assign err_cmd           = r_err_cmd;
    assign app_rd_data       = r_rd_data;
    assign app_rd_data_valid = r_vld[RD_LATENCY-1];
    assign app_rd_data_end   = r_vld[RD_LATENCY-1];
    ddr3_ui_wdf_fifo u_wdf_fifo (
        .clk     (ddr3_app_clk),
        .rst_n   (ddr3_rst_n),
        .i_push  (w_push),
        .i_data  ({app_wdf_mask, app_wdf_data}),
        .i_pop   (w_commit),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    // masked bytes keep their old contents
    always_comb begin
        w_keep = '0;
        for (int b = 0; b < MASK_W; b++) w_keep[b*8 +: 8] = {8{w_head.mask[b]}};
    end
    always_ff @(posedge ddr3_app_clk or negedge ddr3_rst_n) begin
        if (!ddr3_rst_n) begin
            r_init_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_phy_rdy     <= 1'b0;
            r_wr_pending  <= 1'b0;
            r_wr_idx      <= '0;
            r_err_wdf_end <= 1'b0;
            r_err_cmd     <= 1'b0;
            r_vld         <= '0;
            r_rd_data     <= '0;
        end else begin
            if (!r_phy_rdy) begin
                r_phy_rdy  <= r_init_cnt == 16'(INIT_CYCLES - 1);
                r_init_cnt <= r_init_cnt + 16'd1;
            end
            r_stall_cnt <= w_stall ? 16'd0 : r_stall_cnt + 16'd1;
            if (w_cmd_acc && w_is_wr) begin
                r_wr_pending <= 1'b1;
                r_wr_idx     <= w_idx;
            end else if (w_commit) begin
                r_wr_pending <= 1'b0;
            end
            if (w_cmd_acc && !w_is_wr && !w_is_rd) r_err_cmd <= 1'b1;
            if (w_push && !app_wdf_end) r_err_wdf_end <= 1'b1;
            r_vld <= {r_vld[RD_LATENCY-2:0], w_cmd_acc & w_is_rd};
            if (r_vld[RD_LATENCY-2]) r_rd_data <= r_dq[RD_LATENCY-2];
        end
    end
    // a commit never shares a cycle with a read acceptance, so reads always see prior commits
    always_ff @(posedge ddr3_app_clk) begin
        if (w_commit) r_mem[r_wr_idx] <= (r_mem[r_wr_idx] & w_keep) | (w_head.data & ~w_keep);
        r_dq[0] <= r_mem[w_idx];
        for (int i = 1; i < RD_LATENCY - 1; i++) r_dq[i] <= r_dq[i-1];
    end
endmodule

// File: tb/tb_ddr3_ui_responder.sv
// tb_ddr3_ui_responder: directed checks of init timing, writes, masking, FIFO ordering, stalls and reset
module tb_ddr3_ui_responder;
    logic         clk;
    logic         rst_n;
    logic [31:0]  addr;
    logic [2:0]   cmd;
    logic         en, en_s, wren, wren_s, wend;
    logic [287:0] wdata;
    logic [35:0]  wmask;
    logic         rdy, wrdy, rdv, rde, phy, ewe, ecmd;
    logic [287:0] rdd;
    logic         rdy_s, wrdy_s, rdv_s, rde_s, phy_s, ewe_s, ecmd_s;
    logic [287:0] rdd_s;
    int           n_tests = 0;
    int           n_fail  = 0;

    ddr3_ui_responder dut (
        .ddr3_app_clk      (clk),
        .ddr3_rst_n        (rst_n),
        .app_addr          (addr),
        .app_cmd           (cmd),
        .app_en            (en),
        .app_wdf_data      (wdata),
        .app_wdf_mask      (wmask),
        .app_wdf_wren      (wren),
        .app_wdf_end       (wend),
        .app_rdy           (rdy),
        .app_wdf_rdy       (wrdy),
        .app_rd_data       (rdd),
        .app_rd_data_valid (rdv),
        .app_rd_data_end   (rde),
        .phy_rdy           (phy),
        .err_wdf_end       (ewe),
        .err_cmd           (ecmd)
    );

    ddr3_ui_responder #(.STALL_PERIOD(3)) dut_s (
        .ddr3_app_clk      (clk),
        .ddr3_rst_n        (rst_n),
        .app_addr          (addr),
        .app_cmd           (cmd),
        .app_en            (en_s),
        .app_wdf_data      (wdata),
        .app_wdf_mask      (wmask),
        .app_wdf_wren      (wren_s),
        .app_wdf_end       (wend),
        .app_rdy           (rdy_s),
        .app_wdf_rdy       (wrdy_s),
        .app_rd_data       (rdd_s),
        .app_rd_data_valid (rdv_s),
        .app_rd_data_end   (rde_s),
        .phy_rdy           (phy_s),
        .err_wdf_end       (ewe_s),
        .err_cmd           (ecmd_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [287:0] pat(input logic [7:0] b);
        return {36{b}};
    endfunction

    task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy(input bit s);
        for (int t = 0; t < 100 && !(s ? rdy_s : rdy); t++) @(negedge clk);
        check("rdy_wait", {287'd0, s ? rdy_s : rdy}, 288'd1);
    endtask

    task automatic cmd_wr(input bit s, input logic [31:0] a, input bit with_data,
                          input logic [287:0] d, input logic [35:0] m);
        wait_rdy(s);
        addr = a;
        cmd  = 3'b000;
        if (s) en_s = 1'b1; else en = 1'b1;
        if (with_data) begin
            wdata = d;
            wmask = m;
            wend  = 1'b1;
            if (s) wren_s = 1'b1; else wren = 1'b1;
        end
        @(negedge clk);
        en = 1'b0; en_s = 1'b0; wren = 1'b0; wren_s = 1'b0;
    endtask

    task automatic beat(input logic [287:0] d, input logic [35:0] m, input logic e);
        wdata = d;
        wmask = m;
        wend  = e;
        wren  = 1'b1;
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [287:0] exp);
        wait_rdy(0);
        addr = a;
        cmd  = 3'b001;
        en   = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int k = 1; k < 4; k++) begin
            check({tag, "_early"}, {287'd0, rdv}, 288'd0);
            @(negedge clk);
        end
        check({tag, "_valid"}, {287'd0, rdv}, 288'd1);
        check({tag, "_end"}, {287'd0, rde}, 288'd1);
        check({tag, "_data"}, rdd, exp);
        @(negedge clk);
    endtask

    initial begin
        int   j, k, lows, bad, seen;
        logic hist [12];
        rst_n = 1'b0;
        addr = '0; cmd = '0; en = 0; en_s = 0; wren = 0; wren_s = 0; wend = 0;
        wdata = '0; wmask = '0;
        repeat (3) @(negedge clk);
        check("rst_phy", {287'd0, phy}, 288'd0);
        check("rst_rdy", {287'd0, rdy}, 288'd0);
        check("rst_wrdy", {287'd0, wrdy}, 288'd0);
        check("rst_valid", {287'd0, rdv}, 288'd0);
        check("rst_data", rdd, 288'd0);
        check("rst_errs", {286'd0, ewe, ecmd}, 288'd0);
        rst_n = 1'b1;
        repeat (63) @(negedge clk);
        check("init_phy63", {287'd0, phy}, 288'd0);
        check("init_rdy63", {287'd0, rdy}, 288'd0);
        @(negedge clk);
        check("init_phy64", {287'd0, phy}, 288'd1);
        check("init_rdy64", {287'd0, rdy}, 288'd1);
        check("init_wrdy64", {287'd0, wrdy}, 288'd1);

        cmd_wr(0, 32'h40, 1, pat(8'hA5), 36'd0);
        check("wr_pending_rdy", {287'd0, rdy}, 288'd0);
        rd_chk("rd40", 32'h40, pat(8'hA5));
        check("hold_valid", {287'd0, rdv}, 288'd0);
        check("hold_data", rdd, pat(8'hA5));

        cmd_wr(0, 32'h80, 1, {288{1'b1}}, 36'd0);
        cmd_wr(0, 32'h80, 1, pat(8'h5A), 36'h0_0000_0001);
        rd_chk("mask", 32'h80, {{35{8'h5A}}, 8'hFF});

        beat(pat(8'h11), 36'd0, 1'b1);
        beat(pat(8'h22), 36'd0, 1'b1);
        beat(pat(8'h33), 36'd0, 1'b1);
        check("fifo3_wrdy", {287'd0, wrdy}, 288'd1);
        cmd_wr(0, 32'h00, 0, '0, '0);
        cmd_wr(0, 32'h08, 0, '0, '0);
        cmd_wr(0, 32'h10, 0, '0, '0);
        rd_chk("order0", 32'h00, pat(8'h11));
        rd_chk("order1", 32'h08, pat(8'h22));
        rd_chk("order2", 32'h10, pat(8'h33));
        for (int i = 0; i < 4; i++) begin
            beat(pat(8'hC0 + 8'(i)), 36'd0, 1'b1);
            if (i == 2) check("fill3_wrdy", {287'd0, wrdy}, 288'd1);
        end
        check("full_wrdy", {287'd0, wrdy}, 288'd0);
        for (int i = 0; i < 4; i++) cmd_wr(0, 32'h200 + 32'(8 * i), 0, '0, '0);
        check("drain_wrdy", {287'd0, wrdy}, 288'd1);
        rd_chk("drain0", 32'h200, pat(8'hC0));
        rd_chk("drain3", 32'h218, pat(8'hC3));
        rd_chk("alias", 32'hA00, pat(8'hC0));

        check("ewe_before", {287'd0, ewe}, 288'd0);
        beat(pat(8'h77), 36'd0, 1'b0);
        check("ewe_set", {287'd0, ewe}, 288'd1);
        cmd_wr(0, 32'h88, 0, '0, '0);
        rd_chk("noend_data", 32'h88, pat(8'h77));
        check("ewe_sticky", {287'd0, ewe}, 288'd1);
        check("ecmd_before", {287'd0, ecmd}, 288'd0);
        wait_rdy(0);
        cmd = 3'b011;
        en  = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("ecmd_set", {287'd0, ecmd}, 288'd1);
        check("ecmd_no_pending", {287'd0, rdy}, 288'd1);

        for (int i = 0; i < 4; i++) cmd_wr(1, 32'h300 + 32'(8 * i), 1, pat(8'hE0 + 8'(i)), 36'd0);
        @(negedge clk);
        j = 0; k = 0;
        cmd = 3'b001;
        for (int c = 0; c < 40 && k < 8; c++) begin
            if (rdv_s) begin
                check("stall_rd", rdd_s, pat(8'hE0 + 8'(k % 4)));
                k++;
            end
            en_s = j < 8;
            addr = 32'h300 + 32'(8 * (j % 4));
            if (c < 12) hist[c] = rdy_s;
            if (rdy_s && j < 8) j++;
            @(negedge clk);
        end
        en_s = 1'b0;
        check("stall_count", 288'(k), 288'd8);
        lows = 0; bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (!hist[i]) lows++;
            if (hist[i] != hist[i+3]) bad++;
        end
        check("stall_lows", 288'(lows), 288'd3);
        check("stall_period", 288'(bad), 288'd0);

        wait_rdy(0);
        addr = 32'h40;
        cmd  = 3'b001;
        en   = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", {281'd0, rdv, rde, phy, rdy, wrdy, ewe, ecmd}, 288'd0);
        check("mid_rst_data", rdd, 288'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            if (rdv) seen++;
            @(negedge clk);
        end
        check("rst_flush", 288'(seen), 288'd0);
        rd_chk("rst_keep", 32'h40, pat(8'hA5));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
